branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Fetch-side counterpart of the EX-stage branch decision in the RV32I pipeline.
//  Predicts taken/target for the IF PC from a direct-mapped BTB with per-entry history.
//  Trains the table from the resolved outcome (br, target) delivered by EX.
//  Flags mispredictions and supplies the redirect PC. Keeps branch/miss statistics.
// PARAMETERS
//  IDX_W   4   index bits; table depth = 2**IDX_W entries
//  TAG_W = 30-IDX_W (localparam): tag bits, pc[31:IDX_W+2]
// PORTS
//  clk             in   1   core clock, all state on rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  if_pc           in   32  PC being fetched
//  pred_taken      out  1   prediction for if_pc (combinational from table state)
//  pred_target     out  32  predicted target; if_pc+4 when pred_taken=0
//  ex_valid        in   1   EX holds a conditional branch (br_type != NOBRANCH)
//  ex_stall        in   1   EX bubbled this cycle; blocks training and counting
//  ex_pc           in   32  PC of the branch in EX
//  ex_br           in   1   resolved outcome from branch decision
//  ex_target       in   32  resolved taken target
//  ex_pred_taken   in   1   prediction carried down the pipe with this branch
//  ex_pred_target  in   32  predicted target carried down the pipe
//  mispredict      out  1   combinational; flush IF/ID and redirect
//  redirect_pc     out  32  ex_br ? ex_target : ex_pc+4
//  br_cnt          out  32  resolved branches counted
//  miss_cnt        out  32  mispredictions counted
// BEHAVIOUR
//  - Entry: valid(1), tag(TAG_W), target(32), hist (2b or 1b, see CONFIGURATION).
//  - idx = pc[IDX_W+1:2]; hit = valid[idx] && tag[idx]==pc[31:IDX_W+2].
//  - Lookup: hit && hist predicts taken -> pred_taken=1, pred_target=target[idx];
//    otherwise pred_taken=0, pred_target=if_pc+4 (mod 2**32, wraps).
//  - Lookup is zero-latency, no bypass: same-cycle update to the same idx is
//    visible to lookups from the next cycle onward.
//  - train = ex_valid && !ex_stall; table written at posedge clk when train.
//  - Train hit: update hist; if ex_br, target <= ex_target.
//  - Train miss, ex_br=1: allocate (overwrite) valid=1, tag, target, hist=weak-taken.
//  - Train miss, ex_br=0: no write (not-taken branches never allocate).
//  - mispredict = ex_valid && !ex_stall && (ex_br != ex_pred_taken ||
//    (ex_br && ex_pred_target != ex_target)). redirect_pc valid only when mispredict.
//  - ex_valid=0: mispredict=0, no table or counter change; ex_* values ignored.
//  - br_cnt +1 on each train; miss_cnt +1 when mispredict; both saturate at
//    32'hFFFF_FFFF (no wrap).
//  - Reset (async assert, any cycle incl. mid-update): all valid=0, hist=weak-not-taken,
//    tags/targets don't-care, br_cnt=0, miss_cnt=0. Hence pred_taken=0,
//    pred_target=if_pc+4, mispredict follows ex_* inputs only.
//    Deassertion synchronised externally.
// CONFIGURATION
//  BTB_2BIT_HIST_EN defined: 2-bit saturating counter per entry,
//    00 SNT, 01 WNT, 10 WT, 11 ST; predict taken when hist[1]=1.
//    Taken: +1 saturating at 11; not-taken: -1 saturating at 00.
//    Allocate -> 10; reset -> 01.
//  BTB_2BIT_HIST_EN undefined: 1-bit history; hist <= ex_br on train hit;
//    allocate -> 1; reset -> 0. Predict taken when hist=1.
// TESTING
//  1 Reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104, br_cnt=miss_cnt=0.
//  2 Train pc=0x100 br=1 target=0x40 pred=0 -> mispredict=1, redirect=0x40,
//    miss_cnt=1; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x40.
//  3 2-bit: from (2), train 0x100 br=0 once -> still predicts taken (10->01 ? no:
//    10->01 predicts not-taken); verify 11 needs two not-taken to flip; 1-bit flips
//    after one.
//  4 Alias, IDX_W=4: allocate 0x100 (idx 0), then train 0x140 br=1 target=0x80 ->
//    0x100 misses (pred_taken=0), 0x140 hits target 0x80.
//  5 Taken, target change: pred_taken=1 pred_target=0x40, ex_target=0x60 ->
//    mispredict=1, redirect=0x60; ex_stall=1 same case -> mispredict=0, no update.
//  6 Preload br_cnt=miss_cnt=0xFFFF_FFFF (force), train mispredict -> both hold;
//    assert rst_n=0 mid-cycle -> counters 0 and pred_taken=0 immediately.

Source files
------------

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with per-entry history, misprediction detection and statistics
// Optional 2-bit saturating history selected by BTB_2BIT_HIST_EN; 1-bit history otherwise.
module branch_target_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic        ex_br,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

`ifdef BTB_2BIT_HIST_EN
    localparam int              HW      = 2;
    localparam logic [HW-1:0]   H_RST   = 2'b01;
    localparam logic [HW-1:0]   H_ALLOC = 2'b10;
`else
    localparam int              HW      = 1;
    localparam logic [HW-1:0]   H_RST   = 1'b0;
    localparam logic [HW-1:0]   H_ALLOC = 1'b1;
`endif

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [HW-1:0]    hist_q   [DEPTH];

    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             if_hit;
    logic             ex_hit;
    logic             train;
    logic             wr_entry;
    logic             wr_hist;
    logic [HW-1:0]    hist_upd;
    logic [HW-1:0]    hist_d;

    // Lookup reads registered table state only; same-cycle training is not bypassed.
    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_pc[31:IDX_W+2]);
    assign pred_taken  = if_hit && hist_q[if_idx][HW-1];
    assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign train  = ex_valid && !ex_stall;

    always_comb begin
        hist_upd = hist_q[ex_idx];
`ifdef BTB_2BIT_HIST_EN
        if (ex_br) begin
            if (hist_q[ex_idx] != 2'b11) hist_upd = hist_q[ex_idx] + 2'b01;
        end else begin
            if (hist_q[ex_idx] != 2'b00) hist_upd = hist_q[ex_idx] - 2'b01;
        end
`else
        hist_upd = ex_br;
`endif
    end

    // A taken branch either refreshes a hitting entry or allocates over whatever is there.
    assign wr_entry = train && ex_br;
    assign wr_hist  = train && (ex_hit || ex_br);
    assign hist_d   = ex_hit ? hist_upd : H_ALLOC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                hist_q[i]  <= H_RST;
            end
        end else begin
            if (wr_entry) valid_q[ex_idx] <= 1'b1;
            if (wr_hist)  hist_q[ex_idx]  <= hist_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_entry) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
        end
    end

    assign mispredict  = train && ((ex_br != ex_pred_taken) ||
                                   (ex_br && (ex_pred_target != ex_target)));
    assign redirect_pc = ex_br ? ex_target : (ex_pc + 32'd4);

    // Statistics saturate rather than wrap.
    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (train && (br_cnt_q != 32'hFFFF_FFFF))        br_cnt_d   = br_cnt_q + 32'd1;
        if (mispredict && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q   <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - randomized self-checking bench for branch_target_predictor
// Reference model tracks the BTB as plain arrays of integers; history is a saturating count.
module tb_branch_target_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic        ex_br;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int checks;
    int failures;

    branch_target_predictor #(.IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_br(ex_br),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BTB_2BIT_HIST_EN
    localparam int HMAX = 3, H_ALLOC = 2, H_RST = 1, TAKEN_TH = 2;
`else
    localparam int HMAX = 1, H_ALLOC = 1, H_RST = 0, TAKEN_TH = 1;
`endif
    localparam longint CMAX = 64'hFFFF_FFFF;

    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_hist  [16];
    longint      m_br;
    longint      m_miss;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_hist[i]  = H_RST;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    function automatic bit m_taken(input logic [31:0] pc);
        int idx;
        idx = int'(pc[5:2]);
        return m_valid[idx] && (m_tag[idx] == int'(pc[31:6])) && (m_hist[idx] >= TAKEN_TH);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[int'(pc[5:2])] : pc + 32'd4;
    endfunction

    task automatic model_train(input logic [31:0] pc, input bit br, input logic [31:0] tgt);
        int idx;
        idx = int'(pc[5:2]);
        if (m_valid[idx] && m_tag[idx] == int'(pc[31:6])) begin
            m_hist[idx] = br ? ((m_hist[idx] < HMAX) ? m_hist[idx] + 1 : HMAX)
                             : ((m_hist[idx] > 0) ? m_hist[idx] - 1 : 0);
            if (br) m_tgt[idx] = tgt;
        end else if (br) begin
            m_valid[idx] = 1;
            m_tag[idx]   = int'(pc[31:6]);
            m_tgt[idx]   = tgt;
            m_hist[idx]  = H_ALLOC;
        end
    endtask

    function automatic bit exp_mp();
        return ex_valid && !ex_stall &&
               ((ex_br != ex_pred_taken) || (ex_br && ex_pred_target != ex_target));
    endfunction

    task automatic set_ex(input logic [31:0] pc, input logic br, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptg, input logic stall);
        @(negedge clk);
        ex_valid = 1'b1; ex_stall = stall; ex_pc = pc; ex_br = br;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
        #1;
    endtask

    task automatic commit_ex();
        bit tr, mp;
        tr = ex_valid && !ex_stall;
        mp = exp_mp();
        @(posedge clk);
        if (tr) begin
            model_train(ex_pc, ex_br, ex_target);
            if (m_br < CMAX) m_br++;
        end
        if (mp && m_miss < CMAX) m_miss++;
        #1;
        ex_valid = 1'b0;
        ex_stall = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_pc = 32'h100;
        ex_valid = 0; ex_stall = 0; ex_pc = 0; ex_br = 0; ex_target = 0;
        ex_pred_taken = 0; ex_pred_target = 0;
        model_reset();
        #3;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0b exp=0", pred_taken); end
        checks++; if (pred_target !== 32'h104) begin failures++; $display("FAIL reset_pred_target got=%h exp=00000104", pred_target); end
        checks++; if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin failures++; $display("FAIL reset_counters got=%h/%h exp=0/0", br_cnt, miss_cnt); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_allocate();
        set_ex(32'h100, 1'b1, 32'h40, 1'b0, 32'h104, 1'b0);
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL alloc_mispredict got=%0b exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h40) begin failures++; $display("FAIL alloc_redirect got=%h exp=00000040", redirect_pc); end
        if_pc = 32'h100; #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alloc_no_bypass got=%0b exp=0", pred_taken); end
        commit_ex();
        checks++; if (miss_cnt !== 32'd1 || br_cnt !== 32'd1) begin failures++; $display("FAIL alloc_counters got=%h/%h exp=1/1", br_cnt, miss_cnt); end
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin failures++; $display("FAIL alloc_lookup got=%0b/%h exp=1/00000040", pred_taken, pred_target); end
    endtask

    task automatic test_hist();
        logic exp_t;
        if_pc = 32'h100;
        set_ex(32'h100, 1'b0, 32'h40, 1'b1, 32'h40, 1'b0);
        commit_ex();
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL hist_one_nt got=%0b exp=0", pred_taken); end
        for (int k = 0; k < 2; k++) begin
            set_ex(32'h100, 1'b1, 32'h40, m_taken(32'h100), m_target(32'h100), 1'b0);
            commit_ex();
        end
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL hist_retrain got=%0b exp=1", pred_taken); end
        set_ex(32'h100, 1'b0, 32'h40, 1'b1, 32'h40, 1'b0);
        commit_ex();
`ifdef BTB_2BIT_HIST_EN
        exp_t = 1'b1;
`else
        exp_t = 1'b0;
`endif
        checks++; if (pred_taken !== exp_t) begin failures++; $display("FAIL hist_strong_one_nt got=%0b exp=%0b", pred_taken, exp_t); end
        set_ex(32'h100, 1'b0, 32'h40, exp_t, 32'h40, 1'b0);
        commit_ex();
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL hist_two_nt got=%0b exp=0", pred_taken); end
    endtask

    task automatic test_alias();
        set_ex(32'h100, 1'b1, 32'h40, 1'b0, 32'h104, 1'b0);
        commit_ex();
        set_ex(32'h140, 1'b1, 32'h80, 1'b0, 32'h144, 1'b0);
        commit_ex();
        if_pc = 32'h100; #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin failures++; $display("FAIL alias_evicted got=%0b/%h exp=0/00000104", pred_taken, pred_target); end
        if_pc = 32'h140; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin failures++; $display("FAIL alias_new got=%0b/%h exp=1/00000080", pred_taken, pred_target); end
    endtask

    task automatic test_target_change();
        logic [31:0] b0, m0;
        b0 = br_cnt; m0 = miss_cnt;
        set_ex(32'h140, 1'b1, 32'h60, 1'b1, 32'h80, 1'b1);
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL stall_mispredict got=%0b exp=0", mispredict); end
        commit_ex();
        if_pc = 32'h140; #1;
        checks++; if (br_cnt !== b0 || miss_cnt !== m0 || pred_target !== 32'h80) begin failures++; $display("FAIL stall_no_update got=%h/%h/%h exp=%h/%h/00000080", br_cnt, miss_cnt, pred_target, b0, m0); end
        set_ex(32'h140, 1'b1, 32'h60, 1'b1, 32'h80, 1'b0);
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h60) begin failures++; $display("FAIL tgt_change got=%0b/%h exp=1/00000060", mispredict, redirect_pc); end
        commit_ex();
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h60) begin failures++; $display("FAIL tgt_update got=%0b/%h exp=1/00000060", pred_taken, pred_target); end
        @(negedge clk);
        ex_valid = 1'b0; ex_br = 1'b1; ex_pred_taken = 1'b0; #1;
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL invalid_mispredict got=%0b exp=0", mispredict); end
    endtask

    task automatic test_random();
        logic [31:0] pc, tgt, lpc;
        logic        br, pt, stall, vld;
        logic [31:0] ptg;
        for (int n = 0; n < 300; n++) begin
            pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 0) tgt = m_tgt[int'(pc[5:2])];
            br    = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 4) == 0);
            vld   = ($urandom_range(0, 4) != 0);
            pt  = m_taken(pc);
            ptg = m_target(pc);
            if ($urandom_range(0, 7) == 0) begin pt = ~pt; ptg = $urandom; end
            set_ex(pc, br, tgt, pt, ptg, stall);
            ex_valid = vld; #1;
            checks++; if (mispredict !== exp_mp()) begin failures++; $display("FAIL rnd_mispredict n=%0d got=%0b exp=%0b", n, mispredict, exp_mp()); end
            if (exp_mp()) begin
                checks++; if (redirect_pc !== (br ? tgt : pc + 32'd4)) begin failures++; $display("FAIL rnd_redirect n=%0d got=%h exp=%h", n, redirect_pc, br ? tgt : pc + 32'd4); end
            end
            commit_ex();
            checks++; if (br_cnt !== m_br[31:0] || miss_cnt !== m_miss[31:0]) begin failures++; $display("FAIL rnd_counters n=%0d got=%h/%h exp=%h/%h", n, br_cnt, miss_cnt, m_br[31:0], m_miss[31:0]); end
            lpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) lpc = 32'hFFFF_FFFC;
            if_pc = lpc; #1;
            checks++; if (pred_taken !== m_taken(lpc) || pred_target !== m_target(lpc)) begin failures++; $display("FAIL rnd_lookup pc=%h got=%0b/%h exp=%0b/%h", lpc, pred_taken, pred_target, m_taken(lpc), m_target(lpc)); end
        end
    endtask

    task automatic test_saturate_reset();
        set_ex(32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 1'b0);
        force dut.br_cnt_q   = 32'hFFFF_FFFF;
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_cnt_q;
        release dut.miss_cnt_q;
        m_br = CMAX; m_miss = CMAX;
        commit_ex();
        checks++; if (br_cnt !== 32'hFFFF_FFFF || miss_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold got=%h/%h exp=ffffffff/ffffffff", br_cnt, miss_cnt); end
        if_pc = 32'h200; #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin failures++; $display("FAIL sat_lookup got=%0b/%h exp=1/00000300", pred_taken, pred_target); end
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        model_reset();
        checks++; if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin failures++; $display("FAIL async_rst_counters got=%h/%h exp=0/0", br_cnt, miss_cnt); end
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin failures++; $display("FAIL async_rst_lookup got=%0b/%h exp=0/00000204", pred_taken, pred_target); end
        ex_valid = 1'b1; ex_stall = 1'b0; ex_br = 1'b1; ex_pred_taken = 1'b0; ex_target = 32'h500; #1;
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h500) begin failures++; $display("FAIL rst_mispredict got=%0b/%h exp=1/00000500", mispredict, redirect_pc); end
        ex_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_allocate();
        test_hist();
        test_alias();
        test_target_change();
        test_random();
        test_saturate_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
